// File: rtl/pmod_da2_driver.sv
// Two-channel PmodDA2 (DAC121S101 pair) serialiser: one valid/ready sample pair per 16-bit SPI frame.
// Optional power-down control via `define DA2_PWRDN_EN (adds pwrdn input and pwrdn_active output).
module pmod_da2_driver #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  input  logic        sample_valid,
`ifdef DA2_PWRDN_EN
  input  logic [1:0]  pwrdn,
  output logic        pwrdn_active,
`endif
  output logic        sample_ready,
  output logic        frame_done,
  output logic        sync_n,
  output logic        sclk,
  output logic        dina,
  output logic        dinb
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] QUIET = 2'd2;

  localparam logic [7:0] HALF_LAST  = 8'(CLK_DIV - 1);
  localparam logic [8:0] QUIET_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [4:0] LAST_FALL  = 5'd16;

  logic [1:0]  state;
  logic [7:0]  half_cnt;
  logic [4:0]  bit_cnt;
  logic [8:0]  quiet_cnt;
  logic [15:0] shreg_a;
  logic [15:0] shreg_b;
  logic [1:0]  pd_in;
  logic        accept;
  logic        half_wrap;
  logic        frame_end;

`ifdef DA2_PWRDN_EN
  assign pd_in = pwrdn;
`else
  assign pd_in = 2'b00;
`endif

  assign accept    = (state == IDLE) && sample_valid && sample_ready;
  assign half_wrap = (state == SHIFT) && (half_cnt == HALF_LAST);
  // The frame ends on the low-to-high wrap after the 16th fall, so SHIFT spans exactly 32 half-periods.
  assign frame_end = half_wrap && !sclk && (bit_cnt == LAST_FALL);

  // Data lines come straight from the shift register MSB; registers are cleared outside SHIFT.
  assign dina = shreg_a[15];
  assign dinb = shreg_b[15];

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      sample_ready <= 1'b0;
      frame_done   <= 1'b0;
      sync_n       <= 1'b1;
      sclk         <= 1'b1;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      quiet_cnt    <= '0;
      shreg_a      <= '0;
      shreg_b      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= SHIFT;
            sample_ready <= 1'b0;
            sync_n       <= 1'b0;
            sclk         <= 1'b1;
            half_cnt     <= '0;
            bit_cnt      <= '0;
            shreg_a      <= {2'b00, pd_in, sample_a};
            shreg_b      <= {2'b00, pd_in, sample_b};
          end else begin
            sample_ready <= 1'b1;
          end
        end

        SHIFT: begin
          if (half_wrap) begin
            half_cnt <= '0;
            if (sclk) begin
              sclk <= 1'b0;
              if (bit_cnt != LAST_FALL) begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end else if (frame_end) begin
              state      <= QUIET;
              sync_n     <= 1'b1;
              sclk       <= 1'b1;
              bit_cnt    <= '0;
              quiet_cnt  <= '0;
              shreg_a    <= '0;
              shreg_b    <= '0;
              frame_done <= 1'b1;
            end else begin
              sclk    <= 1'b1;
              shreg_a <= {shreg_a[14:0], 1'b0};
              shreg_b <= {shreg_b[14:0], 1'b0};
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        QUIET: begin
          if (quiet_cnt == QUIET_LAST) begin
            state        <= IDLE;
            sample_ready <= 1'b1;
          end else begin
            quiet_cnt <= quiet_cnt + 9'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DA2_PWRDN_EN
  logic [1:0] pd_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pd_q         <= '0;
      pwrdn_active <= 1'b0;
    end else begin
      if (accept) begin
        pd_q <= pwrdn;
      end
      if (frame_end) begin
        pwrdn_active <= |pd_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmod_da2_driver.sv
// Self-checking bench for pmod_da2_driver: decodes the SPI pins into words and compares against
// the expected frame content and latencies computed from the sample/pwrdn values and CLK_DIV.
module tb_pmod_da2_driver;

  localparam int unsigned DIV = 2;
  localparam int FRAME_LOW = 32 * DIV;
  localparam int READY_AT  = 34 * DIV;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample_a = '0;
  logic [11:0] sample_b = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        frame_done;
  logic        sync_n;
  logic        sclk;
  logic        dina;
  logic        dinb;
`ifdef DA2_PWRDN_EN
  logic [1:0]  pwrdn = '0;
  logic        pwrdn_active;
`endif

  pmod_da2_driver #(.CLK_DIV(DIV)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .sample_valid (sample_valid),
`ifdef DA2_PWRDN_EN
    .pwrdn        (pwrdn),
    .pwrdn_active (pwrdn_active),
`endif
    .sample_ready (sample_ready),
    .frame_done   (frame_done),
    .sync_n       (sync_n),
    .sclk         (sclk),
    .dina         (dina),
    .dinb         (dinb)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pin-level decoder: one record per completed SYNC-low window.
  typedef struct {
    int          start;
    int          low;
    int          falls;
    logic [15:0] wa;
    logic [15:0] wb;
  } frame_t;

  frame_t      frames[$];
  int          done_q[$];
  int          ready_q[$];
  frame_t      cur;
  logic        in_frame = 1'b0;
  logic        prev_sclk = 1'b1;
  logic        prev_ready = 1'b0;
  int          mon_falls = 0;

  always @(negedge clock) begin
    if (reset) begin
      in_frame  = 1'b0;
      mon_falls = 0;
    end else begin
      if (!in_frame && !sync_n) begin
        in_frame  = 1'b1;
        cur.start = cyc;
        cur.low   = 0;
        cur.falls = 0;
        cur.wa    = '0;
        cur.wb    = '0;
      end
      if (in_frame) begin
        if (!sync_n) begin
          cur.low++;
          if (prev_sclk && !sclk) begin
            cur.falls++;
            cur.wa = {cur.wa[14:0], dina};
            cur.wb = {cur.wb[14:0], dinb};
          end
          mon_falls = cur.falls;
        end else begin
          frames.push_back(cur);
          in_frame  = 1'b0;
          mon_falls = 0;
        end
      end
      if (frame_done) done_q.push_back(cyc);
      if (sample_ready && !prev_ready) ready_q.push_back(cyc);
    end
    prev_sclk  = sclk;
    prev_ready = sample_ready;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_q();
    frames.delete();
    done_q.delete();
    ready_q.delete();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!sample_ready && n < 300) begin
      step();
      n++;
    end
    check("ready_wait", {31'b0, sample_ready}, 32'd1);
  endtask

  // Presents one pair, returns the accept edge index (cyc value seen right after it).
  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] pd, output int t);
    wait_ready();
    sample_a     = a;
    sample_b     = b;
`ifdef DA2_PWRDN_EN
    pwrdn        = pd;
`endif
    sample_valid = 1'b1;
    step();
    t = cyc;
    sample_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [11:0] a, input logic [11:0] b,
                           input logic [1:0] pd, input bit scramble);
    int          t;
    logic [1:0]  pd_exp;
`ifdef DA2_PWRDN_EN
    pd_exp = pd;
`else
    pd_exp = 2'b00;
`endif
    clear_q();
    send(a, b, pd, t);
    while (cyc < t + READY_AT + 2) begin
      if (scramble) begin
        sample_a = 12'($urandom);
        sample_b = 12'($urandom);
`ifdef DA2_PWRDN_EN
        pwrdn    = 2'($urandom);
`endif
        sample_valid = (cyc < t + FRAME_LOW) ? 1'($urandom) : 1'b0;
      end
      step();
    end
    sample_valid = 1'b0;
    check({tag, "_nframes"}, frames.size(), 1);
    if (frames.size() >= 1) begin
      check({tag, "_start"}, frames[0].start, t);
      check({tag, "_low"},   frames[0].low, FRAME_LOW);
      check({tag, "_falls"}, frames[0].falls, 16);
      check({tag, "_wa"},    frames[0].wa, {2'b00, pd_exp, a});
      check({tag, "_wb"},    frames[0].wb, {2'b00, pd_exp, b});
    end
    check({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() >= 1) check({tag, "_done_at"}, done_q[0] - t, FRAME_LOW);
    check({tag, "_nready"}, ready_q.size(), 1);
    if (ready_q.size() >= 1) check({tag, "_ready_at"}, ready_q[0] - t, READY_AT);
`ifdef DA2_PWRDN_EN
    check({tag, "_pwrdn_active"}, {31'b0, pwrdn_active}, {31'b0, (pd != 2'b00)});
`endif
  endtask

  logic [11:0] steps [3];
  int          acc [3];

  initial begin
    int n;
    // Reset held five cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_outputs", {26'b0, sync_n, sclk, dina, dinb, frame_done, sample_ready}, 32'b110000);
    end
    reset = 1'b0;
    step();
    check("ready_after_reset", {31'b0, sample_ready}, 32'd1);
    check("idle_outputs", {28'b0, sync_n, sclk, dina, dinb}, 32'b1100);

    run_frame("directed", 12'hA5C, 12'h3F0, 2'b00, 1'b0);
    run_frame("scrambled", 12'h5A3, 12'hC0F, 2'b00, 1'b1);
    run_frame("min_max", 12'h000, 12'hFFF, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      run_frame("random", 12'($urandom), 12'($urandom), 2'($urandom), 1'b1);
    end

    // Back-to-back with valid held high.
    steps[0] = 12'd0;
    steps[1] = 12'd4095;
    steps[2] = 12'd2048;
    clear_q();
    wait_ready();
    sample_b     = 12'h111;
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_a = steps[i];
      n = 0;
      while (!sample_ready && n < 300) begin
        step();
        n++;
      end
      check("b2b_ready_wait", {31'b0, sample_ready}, 32'd1);
      step();
      acc[i] = cyc;
    end
    sample_valid = 1'b0;
    while (cyc < acc[2] + READY_AT + 2) step();
    check("b2b_nframes", frames.size(), 3);
    if (frames.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("b2b_word", frames[i].wa, {4'b0000, steps[i]});
        if (i > 0) check("b2b_spacing", frames[i].start - frames[i-1].start, 1 + READY_AT);
      end
    end

    // Reset at the 8th falling edge aborts the frame without frame_done.
    clear_q();
    send(12'h777, 12'h888, 2'b00, n);
    n = 0;
    while (mon_falls < 8 && n < 200) begin
      step();
      n++;
    end
    check("abort_reached_8_falls", mon_falls, 8);
    reset = 1'b1;
    step();
    check("abort_outputs", {26'b0, sync_n, sclk, dina, dinb, frame_done, sample_ready}, 32'b110000);
    step();
    reset = 1'b0;
    step();
    check("abort_ready", {31'b0, sample_ready}, 32'd1);
    for (int i = 0; i < 2 * READY_AT; i++) step();
    check("abort_no_done", done_q.size(), 0);
    check("abort_no_frame", frames.size(), 0);
    run_frame("after_abort", 12'h9B1, 12'h2C4, 2'b00, 1'b0);

`ifdef DA2_PWRDN_EN
    run_frame("pwrdn_hiz", 12'h123, 12'h456, 2'b11, 1'b0);
    run_frame("pwrdn_clear", 12'h123, 12'h456, 2'b00, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
